// File: rtl/gci_std_display_char_draw.sv
// Character draw engine: fetches an 8x14 glyph from the font ROM and emits one VRAM pixel write per glyph pixel.
// Optional build macro GCI_STD_DISPLAY_CHAR_TRANSPARENT_EN skips background pixels instead of painting them.
//
// state    | meaning
// ST_IDLE  | waiting for a draw request
// ST_FETCH | font ROM address valid, glyph latched at end of cycle
// ST_DRAW  | presenting pixels row-major, honouring iVRAM_LOCK
// ST_DONE  | one-cycle completion pulse
module gci_std_display_char_draw #(
    parameter int P_AREA_H  = 640,
    parameter int P_AREA_V  = 480,
    parameter int P_ADDR_W  = 19,
    parameter int P_COLOR_W = 16
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 iIF_REQ,
    output logic                 oIF_BUSY,
    input  logic [6:0]           iIF_ASCII,
    input  logic [9:0]           iIF_X,
    input  logic [8:0]           iIF_Y,
    input  logic [P_COLOR_W-1:0] iIF_FG_COLOR,
    input  logic [P_COLOR_W-1:0] iIF_BG_COLOR,
    output logic [6:0]           oFONT_ADDR,
    input  logic [111:0]         iFONT_DATA,
    output logic                 oVRAM_REQ,
    input  logic                 iVRAM_LOCK,
    output logic [P_ADDR_W-1:0]  oVRAM_ADDR,
    output logic [P_COLOR_W-1:0] oVRAM_DATA,
    output logic                 oDONE
);

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAW, ST_DONE} state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [9:0]             r_x;
    logic [8:0]             r_y;
    logic [P_COLOR_W-1:0]   r_fg;
`ifndef GCI_STD_DISPLAY_CHAR_TRANSPARENT_EN
    logic [P_COLOR_W-1:0]   r_bg;
`endif
    logic [111:0]           r_glyph;
    logic [3:0]             r_row;
    logic [2:0]             r_col;

    logic                   r_busy;
    logic [6:0]             r_font_addr;
    logic                   r_vreq;
    logic [P_ADDR_W-1:0]    r_vaddr;
    logic [P_COLOR_W-1:0]   r_vdata;
    logic                   r_done;

    logic                   w_advance;
    logic                   w_last;
    logic [111:0]           w_glyph_src;
    logic [3:0]             w_row_nxt;
    logic [2:0]             w_col_nxt;
    logic                   w_bit;
    logic [10:0]            w_px;
    logic [10:0]            w_py;
    logic                   w_clip;
    logic                   w_req_nxt;
    logic [P_ADDR_W-1:0]    w_addr_nxt;
    logic [P_COLOR_W-1:0]   w_data_nxt;

    assign oIF_BUSY   = r_busy;
    assign oFONT_ADDR = r_font_addr;
    assign oVRAM_REQ  = r_vreq;
    assign oVRAM_ADDR = r_vaddr;
    assign oVRAM_DATA = r_vdata;
    assign oDONE      = r_done;

    // Skipped pixels (req=0) advance unconditionally; presented writes wait for the lock to drop.
    assign w_advance = (r_state == ST_DRAW) && (!r_vreq || !iVRAM_LOCK);
    assign w_last    = (r_row == 4'd13) && (r_col == 3'd7);

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (iIF_REQ) w_state_next = ST_FETCH;
            ST_FETCH: w_state_next = ST_DRAW;
            ST_DRAW:  if (w_advance && w_last) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Next pixel to present; in FETCH the glyph comes straight from the ROM so pixel 0 is ready next cycle.
    always_comb begin
        w_glyph_src = (r_state == ST_FETCH) ? iFONT_DATA : r_glyph;
        if (r_state == ST_FETCH) begin
            w_row_nxt = 4'd0;
            w_col_nxt = 3'd0;
        end else begin
            w_col_nxt = r_col + 3'd1;
            w_row_nxt = (r_col == 3'd7) ? r_row + 4'd1 : r_row;
        end
        w_bit      = w_glyph_src[7'd111 - {w_row_nxt, w_col_nxt}];
        w_px       = {1'b0, r_x} + {8'b0, w_col_nxt};
        w_py       = {2'b0, r_y} + {7'b0, w_row_nxt};
        w_clip     = (w_px >= 11'(P_AREA_H)) || (w_py >= 11'(P_AREA_V));
        w_addr_nxt = P_ADDR_W'(32'(w_py) * 32'(P_AREA_H) + 32'(w_px));
`ifdef GCI_STD_DISPLAY_CHAR_TRANSPARENT_EN
        w_req_nxt  = !w_clip && w_bit;
        w_data_nxt = r_fg;
`else
        w_req_nxt  = !w_clip;
        w_data_nxt = w_bit ? r_fg : r_bg;
`endif
    end

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            r_x         <= '0;
            r_y         <= '0;
            r_fg        <= '0;
`ifndef GCI_STD_DISPLAY_CHAR_TRANSPARENT_EN
            r_bg        <= '0;
`endif
            r_glyph     <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_busy      <= 1'b0;
            r_font_addr <= '0;
            r_vreq      <= 1'b0;
            r_vaddr     <= '0;
            r_vdata     <= '0;
            r_done      <= 1'b0;
        end else begin
            r_busy <= (w_state_next != ST_IDLE);
            r_done <= (w_state_next == ST_DONE);
            unique case (r_state)
                ST_IDLE: begin
                    if (iIF_REQ) begin
                        r_font_addr <= iIF_ASCII;
                        r_x         <= iIF_X;
                        r_y         <= iIF_Y;
                        r_fg        <= iIF_FG_COLOR;
`ifndef GCI_STD_DISPLAY_CHAR_TRANSPARENT_EN
                        r_bg        <= iIF_BG_COLOR;
`endif
                    end
                end
                ST_FETCH: begin
                    r_glyph <= iFONT_DATA;
                    r_row   <= w_row_nxt;
                    r_col   <= w_col_nxt;
                    r_vreq  <= w_req_nxt;
                    r_vaddr <= w_addr_nxt;
                    r_vdata <= w_data_nxt;
                end
                ST_DRAW: begin
                    if (w_advance) begin
                        if (w_last) begin
                            r_vreq <= 1'b0;
                            r_row  <= '0;
                            r_col  <= '0;
                        end else begin
                            r_row   <= w_row_nxt;
                            r_col   <= w_col_nxt;
                            r_vreq  <= w_req_nxt;
                            r_vaddr <= w_addr_nxt;
                            r_vdata <= w_data_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gci_std_display_char_draw.sv
// Scoreboard bench for gci_std_display_char_draw: a pixel-loop reference model fills an expected-write queue,
// a negedge monitor pops and compares every accepted write and checks hold stability and oDONE timing.
module tb_gci_std_display_char_draw;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req;
    logic         busy;
    logic [6:0]   ascii;
    logic [9:0]   x;
    logic [8:0]   y;
    logic [15:0]  fg;
    logic [15:0]  bg;
    logic [6:0]   font_addr;
    logic [111:0] font_data;
    logic         vreq;
    logic         lock = 1'b0;
    logic [18:0]  vaddr;
    logic [15:0]  vdata;
    logic         done;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int c0 = 0;
    int stalls = 0;
    int accepted = 0;
    int lock_until = 0;
    bit rand_lock = 0;
    bit active = 0;
    bit done_seen = 0;
    bit hold_v = 0;
    logic [18:0] hold_a;
    logic [15:0] hold_d;
    logic [18:0] exp_addr[$];
    logic [15:0] exp_data[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gci_std_display_char_draw dut (
        .iCLOCK(clk), .inRESET(rst_n), .iIF_REQ(req), .oIF_BUSY(busy),
        .iIF_ASCII(ascii), .iIF_X(x), .iIF_Y(y), .iIF_FG_COLOR(fg), .iIF_BG_COLOR(bg),
        .oFONT_ADDR(font_addr), .iFONT_DATA(font_data), .oVRAM_REQ(vreq), .iVRAM_LOCK(lock),
        .oVRAM_ADDR(vaddr), .oVRAM_DATA(vdata), .oDONE(done)
    );

    function automatic logic [111:0] font_rom(input logic [6:0] code);
        logic [127:0] acc;
        logic [31:0]  s;
        if (code <= 7'h20 || code >= 7'h7E) return '0;
        if (code == 7'h2E) return {88'h0, 8'h30, 8'h30, 8'h00};
        if (code == 7'h41)
            return {8'h00, 8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66,
                    8'h66, 8'h66, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00};
        s = {25'd0, code} * 32'h9E3779B1;
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            s = s * 32'd1103515245 + 32'd12345;
            acc = {acc[95:0], s};
        end
        return acc[111:0];
    endfunction

    assign font_data = font_rom(font_addr);

    always @(posedge clk) begin
        #2;
        lock = (cyc < lock_until) || (rand_lock && ($urandom_range(0, 3) == 0));
    end

    task automatic check(input string name, input bit ok, input longint act, input longint expv);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    // Expected writes straight from the pixel rules: visit every glyph pixel, drop the clipped ones.
    task automatic build_model(input logic [6:0] c, input logic [9:0] px, input logic [8:0] py,
                               input logic [15:0] f, input logic [15:0] b);
        logic [111:0] g;
        logic [7:0]   rb;
        int ax, ay;
        g = font_rom(c);
        exp_addr.delete();
        exp_data.delete();
        for (int r = 0; r < 14; r++) begin
            rb = g[111 - 8*r -: 8];
            for (int cc = 0; cc < 8; cc++) begin
                ax = int'(px) + cc;
                ay = int'(py) + r;
                if (ax >= 640 || ay >= 480) continue;
`ifdef GCI_STD_DISPLAY_CHAR_TRANSPARENT_EN
                if (!rb[7-cc]) continue;
                exp_data.push_back(f);
`else
                exp_data.push_back(rb[7-cc] ? f : b);
`endif
                exp_addr.push_back(19'((ay * 640 + ax) % (1 << 19)));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_v)
                check("hold_stable", vreq && vaddr == hold_a && vdata == hold_d, vaddr, hold_a);
            hold_v = vreq && lock;
            hold_a = vaddr;
            hold_d = vdata;
            if (active && vreq && lock) stalls++;
            if (vreq && !lock) begin
                if (!active || exp_addr.size() == 0) begin
                    check("unexpected_write", 1'b0, vaddr, -1);
                end else begin
                    logic [18:0] ea;
                    logic [15:0] ed;
                    ea = exp_addr.pop_front();
                    ed = exp_data.pop_front();
                    check("wr_addr", vaddr == ea, vaddr, ea);
                    check("wr_data", vdata == ed, vdata, ed);
                    accepted++;
                end
            end
            if (done) begin
                if (!active) begin
                    check("spurious_done", 1'b0, 1, 0);
                end else begin
                    check("done_cycle", (cyc - c0 + 1) == 114 + stalls, cyc - c0 + 1, 114 + stalls);
                    check("writes_left", exp_addr.size() == 0, exp_addr.size(), 0);
                    done_seen = 1;
                    active = 0;
                end
            end
        end
    end

    task automatic draw(input logic [6:0] c, input logic [9:0] px, input logic [8:0] py,
                        input logic [15:0] f, input logic [15:0] b,
                        input int dup_at, input int lock_at, input int rst_at);
        int k;
        bit locked;
        locked = 0;
        k = 0;
        while (busy && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        ascii = c; x = px; y = py; fg = f; bg = b; req = 1'b1;
        build_model(c, px, py, f, b);
        stalls = 0; accepted = 0; done_seen = 0; hold_v = 0;
        @(posedge clk); #1;
        c0 = cyc;
        req = 1'b0;
        active = 1;
        check("busy_after_req", busy == 1'b1, busy, 1);
        for (k = 0; k < 3000 && !done_seen; k++) begin
            @(posedge clk); #1;
            // Scramble the request inputs every cycle: the engine must work from its own latches.
            ascii = 7'($urandom); x = 10'($urandom); y = 9'($urandom);
            fg = 16'($urandom); bg = 16'($urandom);
            req = (dup_at > 0) && ((cyc - c0 + 1) == dup_at);
            if (lock_at >= 0 && !locked && accepted == lock_at && vreq) begin
                lock_until = cyc + 5;
                locked = 1;
            end
            if (rst_at >= 0 && accepted == rst_at) begin
                rst_n = 1'b0;
                req = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                check("abort_outputs_zero", {busy, font_addr, vreq, vaddr, vdata, done} == '0,
                      {busy, font_addr, vreq, vaddr, vdata, done}, 0);
                active = 0;
                exp_addr.delete();
                exp_data.delete();
                repeat (130) @(posedge clk);
                #1;
                return;
            end
        end
        req = 1'b0;
        if (!done_seen) check("done_timeout", 1'b0, k, 114);
        else check("idle_after_done", busy == 1'b0, busy, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; ascii = '0; x = '0; y = '0; fg = '0; bg = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, font_addr, vreq, vaddr, vdata, done} == '0,
              {busy, font_addr, vreq, vaddr, vdata, done}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        draw(7'h41, 10'd0,   9'd0,   16'hFFFF, 16'h0000, 0,  -1, -1);
        draw(7'h41, 10'd0,   9'd0,   16'hFFFF, 16'h0000, 0,  20, -1);
        draw(7'h30, 10'd636, 9'd470, 16'h1234, 16'h5678, 0,  -1, -1);
        draw(7'h41, 10'd100, 9'd50,  16'hABCD, 16'h0F0F, 10, -1, -1);
        draw(7'h41, 10'd8,   9'd16,  16'h00FF, 16'hFF00, 114, -1, -1);
        draw(7'h41, 10'd0,   9'd0,   16'hFFFF, 16'h0000, 0,  -1, 50);
        draw(7'h2E, 10'd0,   9'd0,   16'hFFFF, 16'h0000, 0,  -1, -1);
        draw(7'h20, 10'd0,   9'd0,   16'hFFFF, 16'h0000, 0,  -1, -1);
        draw(7'h05, 10'd320, 9'd240, 16'hFFFF, 16'h1111, 0,  -1, -1);

        rand_lock = 1;
        for (int i = 0; i < 8; i++) begin
            logic [9:0] rx;
            logic [8:0] ry;
            if (i % 2 == 0) begin
                rx = 10'($urandom_range(600, 639));
                ry = 9'($urandom_range(440, 479));
            end else begin
                rx = 10'($urandom);
                ry = 9'($urandom);
            end
            draw(7'($urandom), rx, ry, 16'($urandom), 16'($urandom), 0, -1, -1);
        end
        rand_lock = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
